// File: rtl/fpll_pkg.sv
// Shared types and constants for the frequency-lock loop blocks.
package fpll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } k_state_e;

  localparam int ERR_MIN = -128;
  localparam int ERR_MAX = 127;

  // Clamp a signed difference into the 8-bit error range.
  function automatic logic signed [7:0] clamp_err(input int d);
    if (d > ERR_MAX) begin
      return 8'sd127;
    end else if (d < ERR_MIN) begin
      return -8'sd128;
    end else begin
      return 8'(d);
    end
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// SYNC_STAGES must be at least 2.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;

  // Shift the asynchronous input into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/k_estimator.sv
// Gated edge counter that estimates the phase increment k of a square
// wave, reports the window-to-window error and flags when it settles.
//
// state  | meaning
// IDLE   | waiting for enable_i
// GATE   | counting edges for 2^GATE_LOG2 cycles
// REPORT | one-cycle update of outputs, then next window
module k_estimator
  import fpll_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int GATE_LOG2   = 12,
  parameter int TOL         = 2,
  parameter int STABLE_N    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    sig_i,
  output logic [WIDTH-1:0]        k_est_o,
  output logic                    valid_o,
  output logic signed [7:0]       error_o,
  output logic                    stable_o,
  output logic                    overflow_o
);

  localparam int RUN_W = $clog2(STABLE_N + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;

  k_state_e               state_q, state_d;
  logic [GATE_LOG2-1:0]   gate_q, gate_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   win_ovf_q, win_ovf_d;
  logic                   first_q, first_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [WIDTH-1:0]       k_est_q, k_est_d;
  logic                   valid_q, valid_d;
  logic signed [7:0]      err_q, err_d;
  logic                   ovf_out_q, ovf_out_d;

  logic                   edge_pulse;
  logic signed [WIDTH:0]  diff;
  logic signed [7:0]      err_clamped;
  int                     err_abs;
  logic                   qualify;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i  (fpga_clk_i),
    .reset_i(reset_i),
    .sig_i  (sig_i),
    .edge_o (edge_pulse)
  );

  // Next-state, counter and report logic.
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    cnt_d     = cnt_q;
    win_ovf_d = win_ovf_q;
    first_d   = first_q;
    run_d     = run_q;
    k_est_d   = k_est_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    ovf_out_d = ovf_out_q;

    diff        = $signed({1'b0, cnt_q}) - $signed({1'b0, k_est_q});
    err_clamped = clamp_err(int'(diff));
    err_abs     = (err_clamped < 0) ? -int'(err_clamped) : int'(err_clamped);
    qualify     = (err_abs <= TOL) && !win_ovf_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d   = GATE;
          gate_d    = '0;
          cnt_d     = '0;
          win_ovf_d = 1'b0;
          first_d   = 1'b1;
        end
      end
      GATE: begin
        if (!enable_i) begin
          state_d = IDLE;
          run_d   = '0;
        end else begin
          if (edge_pulse) begin
            if (cnt_q == CNT_MAX) begin
              win_ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          gate_d = gate_q + 1'b1;
          if (gate_q == GATE_LAST) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (!enable_i) begin
          state_d = IDLE;
          run_d   = '0;
        end else begin
          k_est_d   = cnt_q;
          valid_d   = 1'b1;
          ovf_out_d = win_ovf_q;
          if (first_q) begin
            err_d = '0;
          end else begin
            err_d = err_clamped;
            if (!qualify) begin
              run_d = '0;
            end else if (run_q != RUN_W'(STABLE_N)) begin
              run_d = run_q + 1'b1;
            end
          end
          first_d   = 1'b0;
          state_d   = GATE;
          gate_d    = '0;
          cnt_d     = '0;
          win_ovf_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      cnt_q     <= '0;
      win_ovf_q <= 1'b0;
      first_q   <= 1'b0;
      run_q     <= '0;
      k_est_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      win_ovf_q <= win_ovf_d;
      first_q   <= first_d;
      run_q     <= run_d;
      k_est_q   <= k_est_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign k_est_o    = k_est_q;
  assign valid_o    = valid_q;
  assign error_o    = err_q;
  assign stable_o   = (run_q == RUN_W'(STABLE_N));
  assign overflow_o = ovf_out_q;

endmodule
